// File: rtl/tinyrisc_pkg.sv
// Shared tinyrisc definitions: datapath width defaults, the memory-access FSM
// encoding and the word-alignment helper used by the memory stage.
package tinyrisc_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mau_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_wb_reg.sv
// Writeback output register: turns a one-cycle retire request into the
// registered wb_* pulse; enables and error flag are forced low between pulses.
module wb_reg #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_we,
  input  logic          i_err,
  input  logic [RW-1:0] i_rd,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic          o_we,
  output logic          o_err,
  output logic [RW-1:0] o_rd,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic          r_we;
  logic          r_err;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_data;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      r_we    <= i_valid & i_we;
      r_err   <= i_valid & i_err;
      if (i_valid) begin
        r_rd   <= i_rd;
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_we    = r_we;
  assign o_err   = r_err;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: ALU ops retire next cycle, loads/stores hold a request
// until mem_ack. Define MEM_ACCESS_MISALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_unit
  import tinyrisc_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_aluResult,
  input  logic [DW-1:0] ex_op2,
  input  logic          ex_isLd,
  input  logic          ex_isSt,
  input  logic          ex_isWb,
  input  logic [RW-1:0] ex_rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign_err
);

  mau_state_t    r_state;
  mau_state_t    w_next_state;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [RW-1:0] r_rd;
  logic          r_is_ld;
  logic          r_we;
  logic          r_is_wb;

  logic          w_accept;
  logic          w_is_mem;
  logic          w_misalign;
  logic          w_capture;
  logic          w_ret_valid;
  logic          w_ret_we;
  logic          w_ret_err;
  logic [RW-1:0] w_ret_rd;
  logic [DW-1:0] w_ret_data;

  assign ex_ready = (r_state == IDLE) && !rst;
  assign w_accept = ex_valid && ex_ready;
  assign w_is_mem = ex_isLd | ex_isSt;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem && is_misaligned(ex_aluResult[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_ret_valid  = 1'b0;
    w_ret_we     = 1'b0;
    w_ret_err    = 1'b0;
    w_ret_rd     = r_rd;
    w_ret_data   = r_addr;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mem && !w_misalign) begin
            w_next_state = REQ;
            w_capture    = 1'b1;
          end else begin
            // ALU op, or a trapped misaligned access retiring without memory
            w_ret_valid = 1'b1;
            w_ret_we    = ex_isWb && !w_is_mem;
            w_ret_err   = w_misalign;
            w_ret_rd    = ex_rd;
            w_ret_data  = ex_aluResult;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          w_next_state = IDLE;
          w_ret_valid  = 1'b1;
          w_ret_we     = r_is_wb && r_is_ld;
          w_ret_data   = r_is_ld ? mem_rdata : r_addr;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the request registers are reset too, because mem_addr/mem_wdata must read 0 in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_is_ld <= 1'b0;
      r_we    <= 1'b0;
      r_is_wb <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= ex_aluResult;
      r_wdata <= ex_op2;
      r_rd    <= ex_rd;
      r_is_ld <= ex_isLd;
      r_we    <= ex_isSt && !ex_isLd;
      r_is_wb <= ex_isWb;
    end
  end

  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  wb_reg #(
    .DW(DW),
    .RW(RW)
  ) u_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_ret_valid),
    .i_we   (w_ret_we),
    .i_err  (w_ret_err),
    .i_rd   (w_ret_rd),
    .i_data (w_ret_data),
    .o_valid(wb_valid),
    .o_we   (wb_we),
    .o_err  (misalign_err),
    .o_rd   (wb_rd),
    .o_data (wb_data)
  );

endmodule
